// File: rtl/xdma_pkg.sv
// Shared types for the XDMA finish path: the remote finish frame layout and
// the finish-sender FSM state encoding.
package xdma_pkg;

  localparam int unsigned FinishIdW = 16;
  localparam logic [7:0]  FinishTag = 8'hF1;

  // Frame written to the previous hop; the tag lets the receiver tell a
  // finish notification apart from other remote writes to the same window.
  typedef struct packed {
    logic [7:0]           tag;
    logic [FinishIdW-1:0] dma_id;
  } xdma_to_remote_finish_t;

  typedef enum logic [1:0] {
    Idle    = 2'd0,
    Issue   = 2'd1,
    WaitRsp = 2'd2
  } finish_state_e;

  function automatic xdma_to_remote_finish_t pack_finish(input logic [FinishIdW-1:0] id);
    xdma_to_remote_finish_t f;
    f.tag    = FinishTag;
    f.dma_id = id;
    return f;
  endfunction

endpackage

// File: rtl/xdma_finish_fifo.sv
// Pending-finish queue: power-of-two circular buffer with occupancy counter
// and a combinational head output.
module xdma_finish_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [Width-1:0]         data_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] r_mem [Depth];
  logic [PtrW-1:0]  r_wr_ptr;
  logic [PtrW-1:0]  r_rd_ptr;
  logic [PtrW:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign full_o  = (r_count == (PtrW+1)'(Depth));
  assign empty_o = (r_count == '0);
  assign count_o = r_count;
  assign data_o  = r_mem[r_rd_ptr];
  assign w_push  = push_i && !full_o;
  assign w_pop   = pop_i && !empty_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PtrW+1)'(1);
        2'b01:   r_count <= r_count - (PtrW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= data_i;
  end

endmodule

// File: rtl/xdma_finish_sender.sv
// Queues finish notifications and sends each as a remote write to the previous
// hop. Define XDMA_FINISH_SENDER_RETRY_EN to resend on error up to MaxRetry times.
module xdma_finish_sender
  import xdma_pkg::*;
#(
  parameter type         id_t     = logic,
  parameter type         addr_t   = logic,
  parameter type         data_t   = logic,
  parameter int unsigned Depth    = 4,
  parameter int unsigned MaxRetry = 3
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  finish_valid_i,
  output logic  finish_ready_o,
  input  addr_t finish_addr_i,
  input  id_t   finish_dma_id_i,
  output logic  wr_valid_o,
  input  logic  wr_ready_i,
  output addr_t wr_addr_o,
  output data_t wr_data_o,
  input  logic  rsp_valid_i,
  input  logic  rsp_error_i,
  output logic  rsp_ready_o,
  output logic  busy_o,
  output logic  drop_o
);

  typedef struct packed {
    addr_t addr;
    id_t   id;
  } entry_t;

  localparam int unsigned EntryW = $bits(entry_t);

  finish_state_e          r_state;
  logic                   r_wr_valid;
  logic                   r_rsp_ready;
  logic                   r_drop;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_rsp_done;
  logic [$clog2(Depth):0] w_count;
  logic [EntryW-1:0]      w_head_raw;
  entry_t                 w_in;
  entry_t                 w_head;
  xdma_to_remote_finish_t w_frame;

`ifdef XDMA_FINISH_SENDER_RETRY_EN
  localparam int unsigned RetryW = (MaxRetry > 0) ? $clog2(MaxRetry + 1) : 1;
  logic [RetryW-1:0] r_retry;
  logic              w_retry_done;
  assign w_retry_done = (r_retry == RetryW'(MaxRetry));
  assign w_rsp_done   = !rsp_error_i || w_retry_done;
`else
  assign w_rsp_done   = 1'b1;
`endif

  assign finish_ready_o = !w_full;
  assign w_push         = finish_valid_i && finish_ready_o;
  assign w_pop          = (r_state == WaitRsp) && rsp_valid_i && w_rsp_done;
  assign w_in.addr      = finish_addr_i;
  assign w_in.id        = finish_dma_id_i;
  assign w_head         = entry_t'(w_head_raw);
  assign w_frame        = pack_finish(FinishIdW'(w_head.id));

  assign wr_valid_o  = r_wr_valid;
  assign wr_addr_o   = w_head.addr;
  assign wr_data_o   = data_t'(w_frame);
  assign rsp_ready_o = r_rsp_ready;
  assign drop_o      = r_drop;
  assign busy_o      = (w_count != '0) || (r_state != Idle);

  xdma_finish_fifo #(
    .Depth (Depth),
    .Width (EntryW)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (w_push),
    .data_i  (w_in),
    .pop_i   (w_pop),
    .data_o  (w_head_raw),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (w_count)
  );

  // The head entry stays in the queue until its response retires it, so the
  // address and frame remain stable across stalls and retries.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= Idle;
      r_wr_valid  <= 1'b0;
      r_rsp_ready <= 1'b0;
      r_drop      <= 1'b0;
`ifdef XDMA_FINISH_SENDER_RETRY_EN
      r_retry     <= '0;
`endif
    end else begin
      r_drop <= 1'b0;
      unique case (r_state)
        Idle: begin
          if (!w_empty) begin
            r_state    <= Issue;
            r_wr_valid <= 1'b1;
          end
        end
        Issue: begin
          if (wr_ready_i) begin
            r_state     <= WaitRsp;
            r_wr_valid  <= 1'b0;
            r_rsp_ready <= 1'b1;
          end
        end
        WaitRsp: begin
          if (rsp_valid_i) begin
            r_rsp_ready <= 1'b0;
`ifdef XDMA_FINISH_SENDER_RETRY_EN
            if (!w_rsp_done) begin
              r_retry    <= r_retry + RetryW'(1);
              r_state    <= Issue;
              r_wr_valid <= 1'b1;
            end else begin
              r_retry <= '0;
              r_drop  <= rsp_error_i;
              r_state <= Idle;
            end
`else
            r_drop  <= rsp_error_i;
            r_state <= Idle;
`endif
          end
        end
        default: begin
          r_state     <= Idle;
          r_wr_valid  <= 1'b0;
          r_rsp_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xdma_finish_sender.sv
// Scoreboard bench for xdma_finish_sender; expectations adapt to whether
// XDMA_FINISH_SENDER_RETRY_EN is defined for the build.
module tb_xdma_finish_sender;

`ifdef XDMA_FINISH_SENDER_RETRY_EN
  localparam bit RetryEn = 1'b1;
`else
  localparam bit RetryEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        finish_valid_i = 1'b0;
  logic        finish_ready_o;
  logic [31:0] finish_addr_i = '0;
  logic [7:0]  finish_dma_id_i = '0;
  logic        wr_valid_o;
  logic        wr_ready_i = 1'b1;
  logic [31:0] wr_addr_o;
  logic [31:0] wr_data_o;
  logic        rsp_valid_i = 1'b0;
  logic        rsp_error_i = 1'b0;
  logic        rsp_ready_o;
  logic        busy_o;
  logic        drop_o;

  int          n_chk = 0;
  int          n_fail = 0;
  int          drop_cnt = 0;
  int          drop_base;
  bit          auto_rsp = 1'b1;
  logic [63:0] exp_q[$];
  bit          rsp_q[$];

  xdma_finish_sender #(
    .id_t     (logic [7:0]),
    .addr_t   (logic [31:0]),
    .data_t   (logic [31:0]),
    .Depth    (4),
    .MaxRetry (3)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .finish_valid_i  (finish_valid_i),
    .finish_ready_o  (finish_ready_o),
    .finish_addr_i   (finish_addr_i),
    .finish_dma_id_i (finish_dma_id_i),
    .wr_valid_o      (wr_valid_o),
    .wr_ready_i      (wr_ready_i),
    .wr_addr_o       (wr_addr_o),
    .wr_data_o       (wr_data_o),
    .rsp_valid_i     (rsp_valid_i),
    .rsp_error_i     (rsp_error_i),
    .rsp_ready_o     (rsp_ready_o),
    .busy_o          (busy_o),
    .drop_o          (drop_o)
  );

  always #5 clk = ~clk;

  // Frame = {8'h00, tag 8'hF1, 16-bit dma_id}
  function automatic logic [31:0] frame(input logic [7:0] id);
    return 32'h00F1_0000 | {24'h0, id};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] a, input logic [7:0] id, input int reps);
    bit acc = 1'b0;
    for (int r = 0; r < reps; r++) exp_q.push_back({a, frame(id)});
    finish_valid_i  = 1'b1;
    finish_addr_i   = a;
    finish_dma_id_i = id;
    for (int c = 0; c < 100 && !acc; c++) begin
      @(negedge clk);
      acc = finish_ready_o;
      @(posedge clk);
      #1;
    end
    finish_valid_i = 1'b0;
    check($sformatf("push_accept_id%0d", id), 64'(acc), 64'd1);
  endtask

  task automatic wait_idle(input string name);
    bit idle = 1'b0;
    for (int c = 0; c < 200 && !idle; c++) begin
      @(negedge clk);
      idle = !busy_o;
    end
    @(negedge clk);
    check(name, 64'(idle), 64'd1);
    @(posedge clk);
    #1;
  endtask

  // Write-request monitor
  initial forever begin
    @(negedge clk);
    if (rst_ni && wr_valid_o && wr_ready_i) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL wr_unexpected: got addr %0h data %0h required none", wr_addr_o, wr_data_o);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if ({wr_addr_o, wr_data_o} !== e) begin
          n_fail++;
          $display("FAIL wr_req: got %0h_%0h expected %0h_%0h", wr_addr_o, wr_data_o, e[63:32], e[31:0]);
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (drop_o) drop_cnt++;
  end

  // Responder: one response per WaitRsp, error bits taken from rsp_q
  initial forever begin
    @(negedge clk);
    if (auto_rsp && rst_ni && rsp_ready_o) begin
      rsp_valid_i = 1'b1;
      rsp_error_i = (rsp_q.size() != 0) ? rsp_q.pop_front() : 1'b0;
      @(posedge clk);
      #1;
      rsp_valid_i = 1'b0;
      rsp_error_i = 1'b0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int reps;
    bit acc;
    #1;
    check("rst_wr_valid", 64'(wr_valid_o), 0);
    check("rst_rsp_ready", 64'(rsp_ready_o), 0);
    check("rst_busy", 64'(busy_o), 0);
    check("rst_drop", 64'(drop_o), 0);
    check("rst_finish_ready", 64'(finish_ready_o), 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    @(posedge clk);
    #1;

    // Single finish into an empty queue
    drop_base = drop_cnt;
    push(32'h1000, 8'd5, 1);
    @(negedge clk);
    check("lat_wr_valid_c0", 64'(wr_valid_o), 0);
    @(negedge clk);
    check("lat_wr_valid_c1", 64'(wr_valid_o), 1);
    check("lat_wr_addr", 64'(wr_addr_o), 64'h1000);
    check("lat_wr_data", 64'(wr_data_o), 64'h00F1_0005);
    @(posedge clk);
    #1;
    wait_idle("t1_idle");
    check("t1_drops", 64'(drop_cnt - drop_base), 0);

    // Fill the queue while the write channel is stalled
    wr_ready_i = 1'b0;
    for (int i = 1; i <= 4; i++) push(32'h2000 + 32'(i), 8'(i), 1);
    @(negedge clk);
    check("full_ready_low", 64'(finish_ready_o), 0);
    repeat (2) @(negedge clk);
    check("full_ready_held", 64'(finish_ready_o), 0);
    check("stall_wr_valid", 64'(wr_valid_o), 1);
    check("stall_wr_addr", 64'(wr_addr_o), 64'h2001);
    @(posedge clk);
    #1;
    wr_ready_i = 1'b1;
    push(32'h2005, 8'd5, 1);
    wait_idle("t2_idle");

    // Three errors then OK
    drop_base = drop_cnt;
    if (RetryEn) begin
      rsp_q = '{1'b1, 1'b1, 1'b1, 1'b0};
      reps = 4;
    end else begin
      rsp_q = '{1'b1};
      reps = 1;
    end
    push(32'h3000, 8'd7, reps);
    wait_idle("t3_idle");
    check("t3_drops", 64'(drop_cnt - drop_base), RetryEn ? 64'd0 : 64'd1);

    // Retries exhausted: drop, then the next entry goes out
    drop_base = drop_cnt;
    if (RetryEn) begin
      rsp_q = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      reps = 4;
    end else begin
      rsp_q = '{1'b1, 1'b0};
      reps = 1;
    end
    push(32'h3100, 8'd9, reps);
    push(32'h3200, 8'd10, 1);
    wait_idle("t4_idle");
    check("t4_drops", 64'(drop_cnt - drop_base), 64'd1);
    check("t4_rsp_consumed", 64'(rsp_q.size()), 0);

    // Simultaneous push and pop at occupancy 2
    auto_rsp = 1'b0;
    wr_ready_i = 1'b0;
    push(32'h4014, 8'd20, 1);
    push(32'h4015, 8'd21, 1);
    wr_ready_i = 1'b1;
    acc = 1'b0;
    for (int c = 0; c < 50 && !acc; c++) begin
      @(negedge clk);
      acc = rsp_ready_o;
    end
    check("t5_reach_waitrsp", 64'(acc), 1);
    check("t5_occ_before", 64'(dut.u_fifo.count_o), 2);
    exp_q.push_back({32'h4016, frame(8'd22)});
    rsp_valid_i     = 1'b1;
    rsp_error_i     = 1'b0;
    finish_valid_i  = 1'b1;
    finish_addr_i   = 32'h4016;
    finish_dma_id_i = 8'd22;
    @(posedge clk);
    #1;
    rsp_valid_i    = 1'b0;
    finish_valid_i = 1'b0;
    check("t5_occ_after", 64'(dut.u_fifo.count_o), 2);
    auto_rsp = 1'b1;
    wait_idle("t5_idle");

    // Reset while waiting for a response with three queued
    drop_base = drop_cnt;
    auto_rsp = 1'b0;
    push(32'h5030, 8'd30, 1);
    push(32'h5031, 8'd31, 1);
    push(32'h5032, 8'd32, 1);
    acc = 1'b0;
    for (int c = 0; c < 50 && !acc; c++) begin
      @(negedge clk);
      acc = rsp_ready_o;
    end
    check("t6_reach_waitrsp", 64'(acc), 1);
    check("t6_occ", 64'(dut.u_fifo.count_o), 3);
    #2;
    rst_ni = 1'b0;
    #1;
    check("t6_rst_wr_valid", 64'(wr_valid_o), 0);
    check("t6_rst_rsp_ready", 64'(rsp_ready_o), 0);
    check("t6_rst_busy", 64'(busy_o), 0);
    check("t6_rst_drop", 64'(drop_o), 0);
    check("t6_rst_finish_ready", 64'(finish_ready_o), 1);
    check("t6_unissued", 64'(exp_q.size()), 2);
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    @(posedge clk);
    #1;
    auto_rsp = 1'b1;
    push(32'h5040, 8'd40, 1);
    wait_idle("t6_restart_idle");
    check("t6_drops", 64'(drop_cnt - drop_base), 0);

    check("final_exp_empty", 64'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/xdma_finish_sender.md
XDMA_FINISH_SENDER -- requirements
Module: xdma_finish_sender

Interface
REQ-001 SHALL have parameter id_t, default logic: DMA task identifier type.
REQ-002 SHALL have parameter addr_t, default logic: remote finish-target address type.
REQ-003 SHALL have parameter data_t, default logic: remote write data word type.
REQ-004 SHALL have parameter Depth, default 4: pending-finish queue depth; power of two, >=2.
REQ-005 SHALL have parameter MaxRetry, default 3: resend attempts after an error response.
REQ-006 SHALL have port clk_i, input, 1: clock.
REQ-007 SHALL have port rst_ni, input, 1: reset, asynchronous, active-low.
REQ-008 SHALL have port finish_valid_i, input, 1: finish notification offered by the finish manager.
REQ-009 SHALL have port finish_ready_o, output, 1: notification accepted.
REQ-010 SHALL have port finish_addr_i, input, $bits(addr_t): previous-hop address to notify.
REQ-011 SHALL have port finish_dma_id_i, input, $bits(id_t): DMA id being finished.
REQ-012 SHALL have port wr_valid_o, input-side handshake output, 1: remote write request valid.
REQ-013 SHALL have port wr_ready_i, input, 1: remote write request accepted.
REQ-014 SHALL have port wr_addr_o, output, $bits(addr_t): remote write address.
REQ-015 SHALL have port wr_data_o, output, $bits(data_t): packed finish frame.
REQ-016 SHALL have port rsp_valid_i, input, 1: write response valid.
REQ-017 SHALL have port rsp_error_i, input, 1: write response is an error.
REQ-018 SHALL have port rsp_ready_o, output, 1: response consumed.
REQ-019 SHALL have port busy_o, output, 1: queue non-empty or transaction in flight.
REQ-020 SHALL have port drop_o, output, 1: one-cycle pulse when a finish is discarded after failed retries.

Function
REQ-021 Queue SHALL store {addr, dma_id} in FIFO order; push on finish_valid_i && finish_ready_o.
REQ-022 finish_ready_o SHALL equal !full, registered-state only; no push when full even if popping same cycle.
REQ-023 Occupancy counter SHALL be $clog2(Depth)+1 bits; pointers $clog2(Depth) bits, wrapping Depth-1 -> 0.
REQ-024 FSM states SHALL be Idle, Issue, WaitRsp.
REQ-025 Idle -> Issue when queue non-empty; first wr_valid_o asserts the cycle after entry reaches head (1-cycle latency from push into empty queue).
REQ-026 Issue: wr_valid_o=1, wr_addr_o=head addr, wr_data_o=head dma_id packed into xdma_to_remote_finish_t, zero-extended to data_t; hold stable until wr_ready_i; on handshake -> WaitRsp.
REQ-027 WaitRsp: rsp_ready_o=1; on rsp_valid_i with !rsp_error_i -> pop head, clear retry count, -> Idle.
REQ-028 WaitRsp error with retry count < MaxRetry -> increment count, -> Issue with same head.
REQ-029 WaitRsp error with retry count == MaxRetry -> pop head, pulse drop_o, clear count, -> Idle.
REQ-030 Simultaneous push and pop SHALL keep occupancy unchanged and both pointers advance.
REQ-031 rsp_valid_i outside WaitRsp SHALL be ignored (rsp_ready_o=0).
REQ-032 busy_o SHALL equal (occupancy != 0) || state != Idle.

Reset
REQ-033 Reset SHALL force state Idle, queue empty, retry count 0, all outputs 0 except finish_ready_o=1 after reset release.
REQ-034 Reset mid-transaction SHALL discard queued and in-flight finishes without drop_o pulse.

Configuration
REQ-035 Macro XDMA_FINISH_SENDER_RETRY_EN defined: retry counter and REQ-028 behaviour present.
REQ-036 Macro undefined: no retry counter; any response pops head; error response also pulses drop_o.

Structure
REQ-037 xdma_to_remote_finish_t and FSM state enum SHALL reside in xdma_pkg.
REQ-038 Queue SHALL be sub-module xdma_finish_fifo (push/pop, full/empty, head output).

Verification
REQ-039 Push {addr=0x1000,id=5} into empty queue -> wr_valid_o next cycle, wr_addr_o=0x1000, wr_data_o id field 5; OK response -> busy_o=0.
REQ-040 Push 4 finishes with wr_ready_i=0 -> finish_ready_o=0 after 4th; 5th held; release -> issued in order ids 1,2,3,4.
REQ-041 Errors on 3 consecutive responses then OK (RETRY_EN) -> 4 requests same address, no drop_o.
REQ-042 4 consecutive errors (RETRY_EN, MaxRetry=3) -> drop_o one pulse, next entry issued.
REQ-043 Push while popping at occupancy 2 -> occupancy stays 2, order preserved.
REQ-044 Assert rst_ni low during WaitRsp with 3 queued -> all outputs 0, busy_o=0, no drop_o, clean restart.
